alu_pipe: RTL and testbench

//  Parametrised, registered ALU for the EX stage, with valid/ready handshakes on input and output.

---
 rtl/alu_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops (logic, add/sub, compare, shifts, MFHI/MFLO) return one cycle
// after acceptance. MULT/DIV run WIDTH iterations (shift-add multiply, restoring
// divide on magnitudes) and then write HI/LO, stalling the input side meanwhile.
//
// Optional feature macro: ALU_OVF_EN adds the registered signed-overflow flag 'ovf'.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake; op accepted when both are high
//   in1, in2            operands (shift amount in in1[SHW-1:0])
//   alu_ctl, sign       5-bit op code; sign=1 selects signed SLT/MULT/DIV
//   out_valid/out_ready output handshake; out holds the result
//   busy                MULT/DIV iteration in progress
//   hi, lo              HI/LO registers
//   ovf                 signed ADD/SUB overflow (ALU_OVF_EN only)
//   dbg_state_o         current FSM state for observation
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds its data stable while valid && !ready.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       alu_ctl,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b11000;
    localparam logic [4:0] OP_SRA  = 5'b11001;
    localparam logic [4:0] OP_MULT = 5'b01000;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_MFHI = 5'b01010;
    localparam logic [4:0] OP_MFLO = 5'b01011;

    state_t                 state_q, state_d;
    logic [SHW-1:0]         cnt_q, cnt_d;
    // MUL: {partial product high, multiplier/low product}. DIV: {remainder, quotient}.
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]       dvd_q, dvd_d;      // raw dividend, returned in hi on divide-by-zero
    logic                   neg_lo_q, neg_lo_d; // negate product / quotient at the end
    logic                   neg_hi_q, neg_hi_d; // negate remainder (dividend was negative)
    logic                   div0_q, div0_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
`ifdef ALU_OVF_EN
    logic                   ovf_q, ovf_d;
    logic                   ovf_res;
`endif

    logic                   accept;
    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [WIDTH-1:0]       sum, diff, alu_res;
    logic [WIDTH:0]         mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]     mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]       q_mag, r_mag;

    assign in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;
`ifdef ALU_OVF_EN
    assign ovf         = ovf_q;
`endif

    assign abs_a = (sign && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
    assign abs_b = (sign && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
    assign sum   = in1 + in2;
    assign diff  = in1 - in2;

`ifdef ALU_OVF_EN
    always_comb begin
        ovf_res = 1'b0;
        if (sign && alu_ctl == OP_ADD)
            ovf_res = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        else if (sign && alu_ctl == OP_SUB)
            ovf_res = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
    end
`endif

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = sign ? {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))}
                                    : {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_NOR:  alu_res = ~(in1 | in2);
            OP_XOR:  alu_res = in1 ^ in2;
            OP_SLL:  alu_res = in2 << in1[SHW-1:0];
            OP_SRL:  alu_res = in2 >> in1[SHW-1:0];
            OP_SRA:  alu_res = $signed(in2) >>> in1[SHW-1:0];
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand into the high half when the current
    // multiplier bit (acc_q[0]) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step: shift the next dividend bit into the remainder,
    // keep the subtraction only if it did not go negative.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    assign q_mag    = acc_q[WIDTH-1:0];
    assign r_mag    = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        dvd_d    = dvd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        out_d    = out_q;
        // A presented result leaves on a transfer edge unless replaced below.
        out_valid_d = out_valid_q && !out_ready;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (alu_ctl == OP_MULT || alu_ctl == OP_DIV) begin
                        state_d  = (alu_ctl == OP_MULT) ? S_MUL : S_DIV;
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                        opb_d    = abs_b;
                        dvd_d    = in1;
                        div0_d   = (in2 == '0);
                        neg_lo_d = sign && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        neg_hi_d = sign && in1[WIDTH-1];
                    end else begin
                        out_d       = alu_res;
                        out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
                        ovf_d       = ovf_res;
`endif
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (opb_q == opb_q && div0_q && state_q == S_DONE && dvd_q == dvd_q) begin
                end
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
                ovf_d       = 1'b0;
`endif
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
                out_d = prod_fix[WIDTH-1:0];
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Distinguish the divide epilogue: remembered through the op kind latched at accept.
    logic is_div_q, is_div_d;
    logic [WIDTH-1:0] div_lo, div_hi;

    always_comb begin
        is_div_d = is_div_q;
        if (state_q == S_IDLE && accept)
            is_div_d = (alu_ctl == OP_DIV);
        div_lo = neg_lo_q ? (~q_mag + 1'b1) : q_mag;
        div_hi = neg_hi_q ? (~r_mag + 1'b1) : r_mag;
        if (div0_q) begin
            div_lo = '1;
            div_hi = dvd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            dvd_q       <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div0_q      <= 1'b0;
            is_div_q    <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef ALU_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            dvd_q       <= dvd_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            div0_q      <= div0_d;
            is_div_q    <= is_div_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_OVF_EN
            ovf_q       <= ovf_d;
`endif
            if (state_q == S_DONE && is_div_q) begin
                hi_q  <= div_hi;
                lo_q  <= div_lo;
                out_q <= div_lo;
            end else begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                out_q <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32): directed cases plus randomized traffic,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 32;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b11000;
    localparam logic [4:0] OP_SRA  = 5'b11001;
    localparam logic [4:0] OP_MULT = 5'b01000;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_MFHI = 5'b01010;
    localparam logic [4:0] OP_MFLO = 5'b01011;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, sign, out_valid, out_ready, busy;
    logic [W-1:0] in1, in2, out, hi, lo;
    logic [4:0]   alu_ctl;
    logic [1:0]   dbg_state;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_ctl(alu_ctl), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .busy(busy), .hi(hi), .lo(lo),
`ifdef ALU_OVF_EN
        .ovf(ovf),
`endif
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
`ifdef ALU_OVF_EN
    logic         exp_ovf_q[$];
`endif
    logic [W-1:0] m_hi, m_lo;
    logic [W-1:0] last_out, prev_out;
    time          last_t, prev_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic [W-1:0] r, output logic v);
        longint sa, sb, p, q, rm, ss, sd;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        ss = longint'($signed(a)) + longint'($signed(b));
        sd = longint'($signed(a)) - longint'($signed(b));
        r = '0;
        v = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  begin r = a + b; v = s && (ss > 64'sd2147483647 || ss < -64'sd2147483648); end
            OP_SUB:  begin r = a - b; v = s && (sd > 64'sd2147483647 || sd < -64'sd2147483648); end
            OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = b << a[4:0];
            OP_SRL:  r = b >> a[4:0];
            OP_SRA:  r = $signed(b) >>> a[4:0];
            OP_MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
                r = m_lo;
            end
            OP_DIV: begin
                if (b == '0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    q = sa / sb;
                    rm = sa % sb;
                    m_lo = q[31:0];
                    m_hi = rm[31:0];
                end
                r = m_lo;
            end
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = '0;
        endcase
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no output", out);
            end else begin
                check("sb_out", out, exp_q.pop_front());
`ifdef ALU_OVF_EN
                check("sb_ovf", {31'b0, ovf}, {31'b0, exp_ovf_q.pop_front()});
`endif
            end
            prev_out = last_out;
            last_out = out;
            prev_t   = last_t;
            last_t   = $time;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input bit rnd_rdy);
        logic [W-1:0] r;
        logic         v;
        int           n;
        bit           ok;
        in_valid = 1'b1;
        alu_ctl  = op;
        in1      = a;
        in2      = b;
        sign     = s;
        n        = 0;
        ok       = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept after %0d cycles expected accept", n);
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (ok) begin
            model(op, a, b, s, r, v);
            exp_q.push_back(r);
`ifdef ALU_OVF_EN
            exp_ovf_q.push_back(v);
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Counts edges from the accept edge until out_valid shows; ends at a negedge.
    task automatic wait_result(output int lat, output logic busy_first);
        lat = 0;
        @(negedge clk);
        busy_first = busy;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ---------------- main sequence ----------------
    logic [4:0] ops [14];
    int         lat;
    logic       bf;
    logic [4:0] op;

    initial begin
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR,
                OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_DIV, OP_MFHI, OP_MFLO};
        reset = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; alu_ctl = '0; sign = 1'b0;
        out_ready = 1'b1; m_hi = '0; m_lo = '0;
        last_out = '0; prev_out = '0; last_t = 0; prev_t = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // ADD then SRA back to back
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
        issue(OP_SRA, 32'd4, 32'h8000_0000, 1'b1, 1'b0);
        drain();
        check("add_result", prev_out, 32'h8000_0000);
        check("sra_result", last_out, 32'hF800_0000);
        check("b2b_spacing", 32'(last_t - prev_t), 32'd10);

        // SLT signed / unsigned
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        drain();
        check("slt_signed", prev_out, 32'd1);
        check("slt_unsigned", last_out, 32'd0);

        // MULT -3 * 7 signed
        issue(OP_MULT, -32'sd3, 32'd7, 1'b1, 1'b0);
        wait_result(lat, bf);
        check("mult_busy", bf, 1);
        check("mult_latency", lat, 33);
        check("mult_busy_done", busy, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("mfhi_after_mult", last_out, 32'hFFFF_FFFF);

        // DIV cases
        issue(OP_DIV, -32'sd7, 32'd2, 1'b1, 1'b0);
        wait_result(lat, bf);
        check("div_latency", lat, 33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        issue(OP_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        wait_result(lat, bf);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd5);
        @(posedge clk);
        #1;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_result(lat, bf);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Output stall for 3 cycles after an AND result
        out_ready = 1'b0;
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0);
        in_valid = 1'b1; alu_ctl = OP_OR; in1 = 32'hF0F0_1234; in2 = 32'h0FF0_FFFF; sign = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out", out, 32'h00F0_1234);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        if (in_ready) begin
            logic [W-1:0] r;
            logic         v;
            model(OP_OR, in1, in2, 1'b0, r, v);
            exp_q.push_back(r);
`ifdef ALU_OVF_EN
            exp_ovf_q.push_back(v);
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("stall_and_out", prev_out, 32'h00F0_1234);
        check("stall_or_out", last_out, 32'hFFF0_FFFF);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 250; i++) begin
            int k;
            k = $urandom_range(0, 19);
            op = (k < 14) ? ops[k] : 5'($urandom_range(0, 31));
            issue(op, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        // Reset in the middle of a DIV with nonzero hi/lo
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drain();
        issue(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        exp_q.delete();
`ifdef ALU_OVF_EN
        exp_ovf_q.delete();
`endif
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("mflo_after_abort", last_out, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
